// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 16x16 unsigned multiplier.
package mult_pkg;

    localparam int MULT_W = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Rows per step must divide the 16-bit multiplier into whole chunks.
    function automatic bit rows_legal(input int rows);
        return (rows == 1) || (rows == 2) || (rows == 4) || (rows == 8) || (rows == 16);
    endfunction

endpackage

// File: rtl/mult_row_slice.sv
// Combinational partial-product slice: sums ROWS shifted, bit-masked copies of A
// for the multiplier chunk selected by the current step index.
module mult_row_slice
    import mult_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int STEP_W = 3
) (
    input  logic [MULT_W-1:0] a_i,
    input  logic [ROWS-1:0]   b_chunk_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [PROD_W-1:0] sum_o
);

    logic [PROD_W-1:0] a_ext;

    assign a_ext = {{(PROD_W-MULT_W){1'b0}}, a_i};

    always_comb begin
        sum_o = '0;
        for (int j = 0; j < ROWS; j++) begin
            if (b_chunk_i[j]) begin
                sum_o = sum_o + (a_ext << (int'(step_i) * ROWS + j));
            end
        end
    end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequencing controller for the 16x16 unsigned multiply: operand handshake in,
// ROWS_PER_STEP partial-product rows accumulated per cycle, product handshake out.
module mult16_seq_ctrl
    import mult_pkg::*;
#(
    parameter int ROWS_PER_STEP = 4,
    parameter bit EARLY_EXIT    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output state_e            state_dbg
);

    localparam int N_STEPS = MULT_W / ROWS_PER_STEP;
    localparam int CNT_W   = $clog2(N_STEPS) + 1;

    if (!rows_legal(ROWS_PER_STEP)) begin : g_bad_rows
        $error("mult16_seq_ctrl: ROWS_PER_STEP must be 1, 2, 4, 8 or 16");
    end

    state_e            state_q, state_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MULT_W-1:0] a_q, a_d;
    logic [MULT_W-1:0] b_q, b_d;

    logic [MULT_W-1:0]        b_cur;
    logic [MULT_W-1:0]        b_rest;
    logic [ROWS_PER_STEP-1:0] b_chunk;
    logic [PROD_W-1:0]        row_sum;
    logic                     last_step;
    logic                     rest_zero;

    // b_rest holds the multiplier bits not yet consumed after this step.
    assign b_cur     = b_q >> (ROWS_PER_STEP * int'(cnt_q));
    assign b_rest    = b_q >> (ROWS_PER_STEP * (int'(cnt_q) + 1));
    assign b_chunk   = b_cur[ROWS_PER_STEP-1:0];
    assign last_step = (cnt_q == CNT_W'(N_STEPS - 1));
    assign rest_zero = (b_rest == '0);

    mult_row_slice #(
        .ROWS   (ROWS_PER_STEP),
        .STEP_W (CNT_W)
    ) u_row_slice (
        .a_i       (a_q),
        .b_chunk_i (b_chunk),
        .step_i    (cnt_q),
        .sum_o     (row_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + row_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step || (EARLY_EXIT && rest_zero)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a capture in IDLE.
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    assign product   = acc_q;
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Bench for mult16_seq_ctrl: three configurations driven in lockstep and checked
// against an arithmetic product/latency model.
module tb_mult16_seq_ctrl;
    import mult_pkg::*;

    localparam int NDUT  = 3;
    localparam int N_MAX = 16;
    localparam int ROWS_CFG [NDUT] = '{4, 4, 1};
    localparam bit EE_CFG   [NDUT] = '{1'b0, 1'b1, 1'b0};

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        flush;
    logic        out_ready;

    logic        in_ready_v  [NDUT];
    logic        out_valid_v [NDUT];
    logic        busy_v      [NDUT];
    logic [31:0] product_v   [NDUT];
    state_e      dbg_v       [NDUT];

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vec [10];

    mult16_seq_ctrl #(.ROWS_PER_STEP(4), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .product(product_v[0]), .busy(busy_v[0]), .state_dbg(dbg_v[0])
    );

    mult16_seq_ctrl #(.ROWS_PER_STEP(4), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .product(product_v[1]), .busy(busy_v[1]), .state_dbg(dbg_v[1])
    );

    mult16_seq_ctrl #(.ROWS_PER_STEP(1), .EARLY_EXIT(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .product(product_v[2]), .busy(busy_v[2]), .state_dbg(dbg_v[2])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: cycles from capture to out_valid
    function automatic int exp_lat(input int rows, input bit ee, input logic [15:0] bb);
        int n;
        int hb;
        n  = 16 / rows;
        hb = -1;
        for (int i = 0; i < 16; i++) begin
            if (bb[i]) hb = i;
        end
        if (!ee) return n;
        if (hb < 0) return 1;
        return hb / rows + 1;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic bit all_ready();
        return in_ready_v[0] && in_ready_v[1] && in_ready_v[2];
    endfunction

    function automatic bit all_valid();
        return out_valid_v[0] && out_valid_v[1] && out_valid_v[2];
    endfunction

    task automatic check_idle(input string name, input bit with_product);
        for (int i = 0; i < NDUT; i++) begin
            check({name, "_in_ready"}, i, 32'(in_ready_v[i]), 32'd1);
            check({name, "_out_valid"}, i, 32'(out_valid_v[i]), 32'd0);
            check({name, "_busy"}, i, 32'(busy_v[i]), 32'd0);
            check({name, "_state"}, i, 32'(dbg_v[i]), 32'(IDLE));
            if (with_product) check({name, "_product"}, i, product_v[i], 32'd0);
        end
    endtask

    // driver tasks
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!all_ready() && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 0, 32'(all_ready()), 32'd1);
    endtask

    task automatic issue(input logic [15:0] aa, input logic [15:0] bb);
        wait_idle();
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
    endtask

    task automatic run_op(input logic [15:0] aa, input logic [15:0] bb, input logic [31:0] exp_p,
                          input string tag);
        int lat [NDUT];
        for (int i = 0; i < NDUT; i++) lat[i] = exp_lat(ROWS_CFG[i], EE_CFG[i], bb);
        exp_q.push_back(exp_p);
        out_ready = 1'b1;
        issue(aa, bb);
        for (int k = 1; k <= N_MAX + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                check({tag, "_out_valid"}, i, 32'(out_valid_v[i]), 32'(k == lat[i]));
                check({tag, "_in_ready"}, i, 32'(in_ready_v[i]), 32'(k > lat[i]));
                check({tag, "_busy"}, i, 32'(busy_v[i]), 32'(k <= lat[i]));
                if (k == lat[i]) check({tag, "_product"}, i, product_v[i], exp_q[0]);
            end
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          n;

        vec[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vec[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vec[2] = '{16'h1234, 16'h0003, 32'h0000_369C};
        vec[3] = '{16'h1234, 16'h0000, 32'h0000_0000};
        vec[4] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
        vec[5] = '{16'h0007, 16'h0009, 32'h0000_003F};
        vec[6] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vec[7] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
        vec[8] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vec[9] = '{16'h0000, 16'hFFFF, 32'h0000_0000};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset", 1'b1);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset", 1'b1);

        for (int t = 0; t < 10; t++) begin
            run_op(vec[t].a, vec[t].b, vec[t].p, $sformatf("vec%0d", t));
        end

        for (int r = 0; r < 40; r++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            run_op(ra, rb, {16'h0, ra} * {16'h0, rb}, $sformatf("rnd%0d", r));
        end

        // backpressure: result held while out_ready is low
        exp_q.push_back(32'h0000_FF00);
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0100);
        n = 0;
        while (!all_valid() && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("bp_all_valid", 0, 32'(all_valid()), 32'd1);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                check("bp_hold_valid", i, 32'(out_valid_v[i]), 32'd1);
                check("bp_hold_product", i, product_v[i], exp_q[0]);
                check("bp_hold_in_ready", i, 32'(in_ready_v[i]), 32'd0);
            end
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) check("bp_same_cycle_in_ready", i, 32'(in_ready_v[i]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("bp_after_valid", i, 32'(out_valid_v[i]), 32'd0);
            check("bp_after_in_ready", i, 32'(in_ready_v[i]), 32'd1);
        end
        void'(exp_q.pop_front());

        // flush in the second RUN cycle
        issue(16'h1234, 16'hFFFF);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check_idle("flush", 1'b1);
        repeat (N_MAX + 2) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) check("flush_no_valid", i, 32'(out_valid_v[i]), 32'd0);
        end
        run_op(16'h0007, 16'h0009, 32'h0000_003F, "post_flush");

        // flush beats in_valid in IDLE
        wait_idle();
        flush    = 1'b1;
        in_valid = 1'b1;
        a        = 16'h0005;
        b        = 16'h0005;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("flush_idle", 1'b1);

        // asynchronous reset in the middle of RUN
        issue(16'hFFFF, 16'hFFFF);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_idle("async_reset", 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("reset_release", 1'b1);
        end
        run_op(16'h0002, 16'h0002, 32'h0000_0004, "post_reset_op");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout dut0: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
